// File: rtl/sync_decoder.sv
// -----------------------------------------------------------------------------
// sync_decoder
// Recovers display timing from free-running VGA-style HS/VS inputs.
// Line and frame counters restart on the rising edge of each sync, the
// measured line/frame lengths are published, and a small FSM declares lock
// once a complete frame matches the expected geometry. Loss of lock produces
// a single-cycle SYNC_ERR pulse.
// -----------------------------------------------------------------------------
module sync_decoder #(
  parameter logic [9:0] htotal   = 10'd800,
  parameter logic [9:0] hstart   = 10'd144,
  parameter logic [9:0] hdisplay = 10'd640,
  parameter logic [9:0] vtotal   = 10'd525,
  parameter logic [9:0] vstart   = 10'd35,
  parameter logic [9:0] vdisplay = 10'd480
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  output logic [9:0] HCOUNT,
  output logic [9:0] VCOUNT,
  output logic       DE,
  output logic       LOCKED,
  output logic       SYNC_ERR,
  output logic [9:0] HTOTAL,
  output logic [9:0] VTOTAL
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // End of the active window, one bit wider so hstart+hdisplay cannot wrap.
  localparam logic [10:0] HEND = {1'b0, hstart} + {1'b0, hdisplay};
  localparam logic [10:0] VEND = {1'b0, vstart} + {1'b0, vdisplay};
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  state_t     r_state;
  logic       r_hs_q;
  logic       r_vs_q;
  logic [9:0] r_lcnt;
  logic [9:0] r_vcnt;
  logic [9:0] r_htotal;
  logic [9:0] r_vtotal;
  logic       r_ferr;
  logic       r_sync_err;

  logic       w_hrise;
  logic       w_vrise;
  logic [9:0] w_lcnt_inc;
  logic [9:0] w_vcnt_inc;
  logic       w_lcnt_sat;
  logic       w_vcnt_sat;
  logic       w_line_err;
  logic       w_frame_bad;
  logic       w_h_active;
  logic       w_v_active;
  logic       w_locked;

  // A wide sync pulse yields only one edge; a stuck-high sync yields none.
  assign w_hrise = VGA_HS & ~r_hs_q;
  assign w_vrise = VGA_VS & ~r_vs_q;

  assign w_lcnt_inc = r_lcnt + 10'd1;
  assign w_vcnt_inc = r_vcnt + 10'd1;
  assign w_lcnt_sat = (r_lcnt == CNT_MAX);
  assign w_vcnt_sat = (r_vcnt == CNT_MAX);

  // A line is bad if it ended with the wrong length or never ended at all.
  assign w_line_err  = (w_hrise & (w_lcnt_inc != htotal)) | w_lcnt_sat;
  assign w_frame_bad = w_vrise & (w_vcnt_inc != vtotal);

  assign w_h_active = (r_lcnt >= hstart) && ({1'b0, r_lcnt} < HEND);
  assign w_v_active = (r_vcnt >= vstart) && ({1'b0, r_vcnt} < VEND);
  assign w_locked   = (r_state == ST_LOCKED);

  assign HCOUNT   = r_lcnt - hstart;
  assign VCOUNT   = r_vcnt - vstart;
  assign DE       = w_locked & w_h_active & w_v_active;
  assign LOCKED   = w_locked;
  assign SYNC_ERR = r_sync_err;
  assign HTOTAL   = r_htotal;
  assign VTOTAL   = r_vtotal;

  // Delayed copies of the sync inputs for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs_q <= 1'b0;
      r_vs_q <= 1'b0;
    end else begin
      r_hs_q <= VGA_HS;
      r_vs_q <= VGA_VS;
    end
  end

  // Line counter: restarts on HS edge, captures line length, saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lcnt   <= 10'd0;
      r_htotal <= 10'd0;
    end else if (w_hrise) begin
      r_lcnt   <= 10'd0;
      r_htotal <= w_lcnt_inc;
    end else if (!w_lcnt_sat) begin
      r_lcnt   <= w_lcnt_inc;
    end else begin
      r_lcnt   <= r_lcnt;
    end
  end

  // Frame counter: restarts on VS edge (wins over HS), counts lines, saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vcnt   <= 10'd0;
      r_vtotal <= 10'd0;
    end else if (w_vrise) begin
      r_vcnt   <= 10'd0;
      r_vtotal <= w_vcnt_inc;
    end else if (w_hrise && !w_vcnt_sat) begin
      r_vcnt   <= w_vcnt_inc;
    end else begin
      r_vcnt   <= r_vcnt;
    end
  end

  // Lock FSM with frame-error flag and one-cycle loss-of-lock pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_SEARCH;
      r_ferr     <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_vrise) begin
            r_state <= ST_MEASURE;
            r_ferr  <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_vrise) begin
            // The line closing this frame counts toward the frame as well.
            if (!r_ferr && !w_line_err && !w_frame_bad) begin
              r_state <= ST_LOCKED;
            end
            r_ferr <= 1'b0;
          end else if (w_line_err) begin
            r_ferr <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_line_err || w_frame_bad) begin
            r_state    <= ST_SEARCH;
            r_ferr     <= w_line_err;
            r_sync_err <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_SEARCH;
          r_ferr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_sync_decoder
// Directed bench for sync_decoder using a reduced 50x20 timing so whole
// frames fit in a short run: HS high 6 clocks, VS high 2 lines, active window
// columns 12..43 and lines 4..15.
// -----------------------------------------------------------------------------
module tb_sync_decoder;

  localparam int HS_W     = 6;
  localparam int VS_LINES = 2;
  localparam int H_TOT    = 50;

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b1;
  logic       VGA_HS = 1'b0;
  logic       VGA_VS = 1'b0;
  logic [9:0] HCOUNT;
  logic [9:0] VCOUNT;
  logic [9:0] HTOTAL;
  logic [9:0] VTOTAL;
  logic       DE;
  logic       LOCKED;
  logic       SYNC_ERR;

  int checks = 0;
  int errors = 0;

  // Timing generator position: next pixel/line to drive, and the one just sampled.
  int pix = 0;
  int line = 0;
  int last_pix = 0;
  int last_line = 0;
  int frame_lines = 20;
  int short_line = -1;
  bit hold_low = 1'b0;

  sync_decoder #(
    .htotal  (10'd50),
    .hstart  (10'd12),
    .hdisplay(10'd32),
    .vtotal  (10'd20),
    .vstart  (10'd4),
    .vdisplay(10'd12)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .VGA_HS  (VGA_HS),
    .VGA_VS  (VGA_VS),
    .HCOUNT  (HCOUNT),
    .VCOUNT  (VCOUNT),
    .DE      (DE),
    .LOCKED  (LOCKED),
    .SYNC_ERR(SYNC_ERR),
    .HTOTAL  (HTOTAL),
    .VTOTAL  (VTOTAL)
  );

  always #5 CLK = ~CLK;

  // Drive one pixel position, let the DUT sample it, then advance.
  task automatic tick();
    int len;
    VGA_HS = (!hold_low) && (pix < HS_W);
    VGA_VS = (!hold_low) && (line < VS_LINES);
    @(posedge CLK);
    #1;
    last_pix  = pix;
    last_line = line;
    len = (line == short_line) ? (H_TOT - 1) : H_TOT;
    pix++;
    if (pix >= len) begin
      pix = 0;
      line++;
      if (line >= frame_lines) line = 0;
    end
  endtask

  task automatic run_frame();
    tick();
    while (!(pix == 0 && line == 0)) tick();
  endtask

  task automatic test_reset();
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
    checks++; if (DE !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", DE); end
    checks++; if (SYNC_ERR !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", SYNC_ERR); end
    checks++; if (HTOTAL !== 10'd0) begin errors++; $display("FAIL reset_htotal: got %0d expected 0", HTOTAL); end
    checks++; if (VTOTAL !== 10'd0) begin errors++; $display("FAIL reset_vtotal: got %0d expected 0", VTOTAL); end
    checks++; if (HCOUNT !== 10'd1012) begin errors++; $display("FAIL reset_hcount: got %0d expected 1012", HCOUNT); end
    checks++; if (VCOUNT !== 10'd1020) begin errors++; $display("FAIL reset_vcount: got %0d expected 1020", VCOUNT); end
  endtask

  task automatic test_lock();
    RST_N = 1'b1;
    run_frame();
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", LOCKED); end
    tick();
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", LOCKED); end
    checks++; if (HTOTAL !== 10'd50) begin errors++; $display("FAIL lock_htotal: got %0d expected 50", HTOTAL); end
    checks++; if (VTOTAL !== 10'd20) begin errors++; $display("FAIL lock_vtotal: got %0d expected 20", VTOTAL); end
  endtask

  task automatic test_de();
    int de_cnt = 0;
    int de_bad = 0;
    bit exp_de;
    while (!(pix == 0 && line == 0)) begin
      tick();
      exp_de = (last_pix >= 12) && (last_pix < 44) && (last_line >= 4) && (last_line < 16);
      if (DE === 1'b1) de_cnt++;
      if (DE !== exp_de) de_bad++;
      if (exp_de && ((HCOUNT !== 10'(last_pix - 12)) || (VCOUNT !== 10'(last_line - 4)))) de_bad++;
      if (last_pix == 12 && last_line == 4) begin
        checks++; if (DE !== 1'b1) begin errors++; $display("FAIL de_first: got %b expected 1", DE); end
        checks++; if (HCOUNT !== 10'd0 || VCOUNT !== 10'd0) begin errors++; $display("FAIL de_first_pos: got %0d,%0d expected 0,0", HCOUNT, VCOUNT); end
      end
      if (last_pix == 11 && last_line == 4) begin
        checks++; if (DE !== 1'b0) begin errors++; $display("FAIL de_before: got %b expected 0", DE); end
      end
      if (last_pix == 43 && last_line == 15) begin
        checks++; if (DE !== 1'b1) begin errors++; $display("FAIL de_last: got %b expected 1", DE); end
        checks++; if (HCOUNT !== 10'd31 || VCOUNT !== 10'd11) begin errors++; $display("FAIL de_last_pos: got %0d,%0d expected 31,11", HCOUNT, VCOUNT); end
      end
      if (last_pix == 44 && last_line == 15) begin
        checks++; if (DE !== 1'b0) begin errors++; $display("FAIL de_after: got %b expected 0", DE); end
      end
      if (last_pix == 12 && last_line == 16) begin
        checks++; if (DE !== 1'b0) begin errors++; $display("FAIL de_below: got %b expected 0", DE); end
      end
    end
    checks++; if (de_cnt != 384) begin errors++; $display("FAIL de_count: got %0d expected 384", de_cnt); end
    checks++; if (de_bad != 0) begin errors++; $display("FAIL de_window: got %0d bad cycles expected 0", de_bad); end
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL de_still_locked: got %b expected 1", LOCKED); end
  endtask

  task automatic test_short_line();
    int sync_cnt = 0;
    short_line = 5;
    tick();
    while (!(pix == 0 && line == 0)) begin
      tick();
      if (SYNC_ERR === 1'b1) sync_cnt++;
      if (last_line == 5 && last_pix == 48) begin
        checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL short_pre_locked: got %b expected 1", LOCKED); end
      end
      if (last_line == 6 && last_pix == 0) begin
        checks++; if (SYNC_ERR !== 1'b1) begin errors++; $display("FAIL short_sync_err: got %b expected 1", SYNC_ERR); end
        checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL short_locked: got %b expected 0", LOCKED); end
        checks++; if (DE !== 1'b0) begin errors++; $display("FAIL short_de: got %b expected 0", DE); end
        checks++; if (HTOTAL !== 10'd49) begin errors++; $display("FAIL short_htotal: got %0d expected 49", HTOTAL); end
      end
      if (last_line == 6 && last_pix == 1) begin
        checks++; if (SYNC_ERR !== 1'b0) begin errors++; $display("FAIL short_sync_err_end: got %b expected 0", SYNC_ERR); end
      end
      if (last_line == 6 && last_pix == 20) begin
        checks++; if (DE !== 1'b0) begin errors++; $display("FAIL short_de_window: got %b expected 0", DE); end
      end
    end
    checks++; if (sync_cnt != 1) begin errors++; $display("FAIL short_pulse_count: got %0d expected 1", sync_cnt); end
    short_line = -1;
  endtask

  task automatic test_bad_frame();
    frame_lines = 19;
    run_frame();
    frame_lines = 20;
    tick();
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL badframe_locked: got %b expected 0", LOCKED); end
    checks++; if (VTOTAL !== 10'd19) begin errors++; $display("FAIL badframe_vtotal: got %0d expected 19", VTOTAL); end
    while (!(pix == 0 && line == 0)) tick();
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL badframe_measure: got %b expected 0", LOCKED); end
    tick();
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL badframe_relock: got %b expected 1", LOCKED); end
    checks++; if (VTOTAL !== 10'd20) begin errors++; $display("FAIL badframe_vtotal2: got %0d expected 20", VTOTAL); end
  endtask

  task automatic test_hs_stuck();
    int sync_cnt = 0;
    while (!(pix == 0 && line == 3)) tick();
    tick();
    hold_low = 1'b1;
    for (int t = 1; t <= 1100; t++) begin
      tick();
      if (SYNC_ERR === 1'b1) sync_cnt++;
      if (t == 1023) begin
        checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL stuck_pre_locked: got %b expected 1", LOCKED); end
      end
      if (t == 1024) begin
        checks++; if (SYNC_ERR !== 1'b1 || LOCKED !== 1'b0) begin errors++; $display("FAIL stuck_loss: got sync_err=%b locked=%b expected 1,0", SYNC_ERR, LOCKED); end
      end
    end
    checks++; if (sync_cnt != 1) begin errors++; $display("FAIL stuck_pulse_count: got %0d expected 1", sync_cnt); end
    checks++; if (HCOUNT !== 10'd1011) begin errors++; $display("FAIL stuck_saturate: got %0d expected 1011", HCOUNT); end
    hold_low = 1'b0;
    while (!(pix == 0 && line == 0)) tick();
  endtask

  task automatic test_reset_midline();
    run_frame();
    tick();
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL rst_pre_locked: got %b expected 1", LOCKED); end
    while (!(pix == 21 && line == 5)) tick();
    checks++; if (DE !== 1'b1) begin errors++; $display("FAIL rst_pre_de: got %b expected 1", DE); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (LOCKED !== 1'b0 || DE !== 1'b0 || SYNC_ERR !== 1'b0) begin errors++; $display("FAIL rst_async_flags: got locked=%b de=%b sync_err=%b expected 0,0,0", LOCKED, DE, SYNC_ERR); end
    checks++; if (HTOTAL !== 10'd0 || VTOTAL !== 10'd0) begin errors++; $display("FAIL rst_async_totals: got %0d,%0d expected 0,0", HTOTAL, VTOTAL); end
    checks++; if (HCOUNT !== 10'd1012 || VCOUNT !== 10'd1020) begin errors++; $display("FAIL rst_async_counts: got %0d,%0d expected 1012,1020", HCOUNT, VCOUNT); end
    tick();
    tick();
    RST_N = 1'b1;
    while (!(pix == 0 && line == 0)) tick();
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_partial: got %b expected 0", LOCKED); end
    run_frame();
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_first_vrise: got %b expected 0", LOCKED); end
    tick();
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL rst_relock: got %b expected 1", LOCKED); end
  endtask

  task automatic test_hs_high_release();
    RST_N  = 1'b0;
    VGA_HS = 1'b1;
    VGA_VS = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (HTOTAL !== 10'd1) begin errors++; $display("FAIL release_hrise: got %0d expected 1", HTOTAL); end
    checks++; if (HCOUNT !== 10'd1012) begin errors++; $display("FAIL release_hcount: got %0d expected 1012", HCOUNT); end
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (HTOTAL !== 10'd1) begin errors++; $display("FAIL stuck_high_htotal: got %0d expected 1", HTOTAL); end
    checks++; if (HCOUNT !== 10'd1017) begin errors++; $display("FAIL stuck_high_hcount: got %0d expected 1017", HCOUNT); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_lock();
    test_de();
    test_short_line();
    test_bad_frame();
    test_hs_stuck();
    test_reset_midline();
    test_hs_high_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
